// File: rtl/rggen_register_access_defines.sv
//------------------------------------------------------------------------------
// Module   : rggen_register_access_defines (package)
// Purpose  : Shared encodings for the register-access initiator:
//            command kinds, response status codes and FSM states.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rggen_register_access_defines;

    // Command kinds presented on i_cmd_kind
    localparam logic [1:0] c_kind_read     = 2'b00;
    localparam logic [1:0] c_kind_write    = 2'b01;
    localparam logic [1:0] c_kind_rmw      = 2'b10;
    localparam logic [1:0] c_kind_reserved = 2'b11;

    // Status codes, shared by the access bus and the response port
    localparam logic [1:0] c_status_ok           = 2'b00;
    localparam logic [1:0] c_status_reserved     = 2'b01;
    localparam logic [1:0] c_status_slave_error  = 2'b10;
    localparam logic [1:0] c_status_timeout      = 2'b11;

    // Initiator FSM states
    localparam logic [1:0] c_state_idle  = 2'b00;
    localparam logic [1:0] c_state_read  = 2'b01;
    localparam logic [1:0] c_state_write = 2'b10;
    localparam logic [1:0] c_state_resp  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/rggen_access_timeout_counter.sv
//------------------------------------------------------------------------------
// Module   : rggen_access_timeout_counter
// Purpose  : Wait-cycle counter for one access phase. Clears on i_clear,
//            counts on i_enable, and flags the cycle in which the count
//            reaches TIMEOUT_CYCLES.
// Ports    : i_clk, i_rst_n    - clock, asynchronous active-low reset
//            i_clear           - return the count to zero
//            i_enable          - one more cycle spent waiting
//            o_terminal        - this waiting cycle is the last one allowed
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rggen_access_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    logic [TIMEOUT_WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            assign o_terminal = 1'b0;
        end else begin : g_enabled
            // The count reaches TIMEOUT_CYCLES at the end of the waiting
            // cycle that starts at TIMEOUT_CYCLES-1, so that is the cycle
            // on which the abort decision is made.
            localparam logic [TIMEOUT_WIDTH-1:0] c_last =
                TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
            assign o_terminal = i_enable && (r_count == c_last);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/rggen_register_access_initiator.sv
//------------------------------------------------------------------------------
// Module   : rggen_register_access_initiator
// Purpose  : Requester side of the register access bus. Takes read, write
//            and read-modify-write commands, runs the access phases with a
//            per-phase timeout and returns status plus read data.
// Ports    : i_clk, i_rst_n         - clock, asynchronous active-low reset
//            i_cmd_* / o_cmd_ready  - command port (valid/ready)
//            o_access_* / i_access_* - register access bus
//            o_rsp_* / i_rsp_ready  - response port (valid/ready)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rggen_register_access_initiator
    import rggen_register_access_defines::*;
#(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_cmd_valid,
    output logic                     o_cmd_ready,
    input  logic [1:0]               i_cmd_kind,
    input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
    input  logic [DATA_WIDTH-1:0]    i_cmd_write_data,
    input  logic [DATA_WIDTH-1:0]    i_cmd_mask,
    output logic                     o_access_valid,
    output logic                     o_access_write,
    output logic [ADDRESS_WIDTH-1:0] o_access_address,
    output logic [DATA_WIDTH-1:0]    o_access_write_data,
    output logic [DATA_WIDTH-1:0]    o_access_mask,
    input  logic                     i_access_ready,
    input  logic [1:0]               i_access_status,
    input  logic [DATA_WIDTH-1:0]    i_access_read_data,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [1:0]               o_rsp_status,
    output logic [DATA_WIDTH-1:0]    o_rsp_read_data
);

    logic [1:0]               r_state;
    logic                     r_rmw;
    logic [DATA_WIDTH-1:0]    r_write_data;
    logic [DATA_WIDTH-1:0]    r_mask;
    logic [DATA_WIDTH-1:0]    r_read_data;

    logic                     r_access_valid;
    logic                     r_access_write;
    logic [ADDRESS_WIDTH-1:0] r_access_address;
    logic [DATA_WIDTH-1:0]    r_access_write_data;
    logic [DATA_WIDTH-1:0]    r_access_mask;

    logic                     r_rsp_valid;
    logic [1:0]               r_rsp_status;
    logic [DATA_WIDTH-1:0]    r_rsp_read_data;

    logic                     w_complete;
    logic                     w_waiting;
    logic                     w_timeout;
    logic [DATA_WIDTH-1:0]    w_merged_data;

    assign w_complete = r_access_valid && i_access_ready;
    assign w_waiting  = r_access_valid && !i_access_ready;

    // Bits selected by the mask take the command data, the rest keep the
    // value just read.
    assign w_merged_data = (i_access_read_data & ~r_mask) | (r_write_data & r_mask);

    // Any cycle without a pending access, or a completing one, starts the
    // next phase with a fresh count.
    rggen_access_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
    ) u_timeout (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clear    (!w_waiting),
        .i_enable   (w_waiting),
        .o_terminal (w_timeout)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state             <= c_state_idle;
            r_rmw               <= 1'b0;
            r_write_data        <= '0;
            r_mask              <= '0;
            r_read_data         <= '0;
            r_access_valid      <= 1'b0;
            r_access_write      <= 1'b0;
            r_access_address    <= '0;
            r_access_write_data <= '0;
            r_access_mask       <= '0;
            r_rsp_valid         <= 1'b0;
            r_rsp_status        <= c_status_ok;
            r_rsp_read_data     <= '0;
        end else begin
            case (r_state)
                c_state_idle: begin
                    if (i_cmd_valid) begin
                        r_rmw        <= (i_cmd_kind == c_kind_rmw);
                        r_write_data <= i_cmd_write_data;
                        r_mask       <= i_cmd_mask;
                        r_read_data  <= '0;
                        case (i_cmd_kind)
                            c_kind_read, c_kind_rmw: begin
                                r_state             <= c_state_read;
                                r_access_valid      <= 1'b1;
                                r_access_write      <= 1'b0;
                                r_access_address    <= i_cmd_address;
                                r_access_write_data <= '0;
                                r_access_mask       <= i_cmd_mask;
                            end
                            c_kind_write: begin
                                r_state             <= c_state_write;
                                r_access_valid      <= 1'b1;
                                r_access_write      <= 1'b1;
                                r_access_address    <= i_cmd_address;
                                r_access_write_data <= i_cmd_write_data;
                                r_access_mask       <= i_cmd_mask;
                            end
                            default: begin
                                // Reserved kind: answer at once, no bus traffic
                                r_state         <= c_state_resp;
                                r_rsp_valid     <= 1'b1;
                                r_rsp_status    <= c_status_timeout;
                                r_rsp_read_data <= '0;
                            end
                        endcase
                    end
                end

                c_state_read: begin
                    if (w_complete) begin
                        r_read_data <= i_access_read_data;
                        if (r_rmw && (i_access_status == c_status_ok)) begin
                            // Write phase follows back to back; valid stays up
                            r_state             <= c_state_write;
                            r_access_write      <= 1'b1;
                            r_access_write_data <= w_merged_data;
                            r_access_mask       <= '1;
                        end else begin
                            r_state             <= c_state_resp;
                            r_access_valid      <= 1'b0;
                            r_access_address    <= '0;
                            r_access_mask       <= '0;
                            r_rsp_valid         <= 1'b1;
                            r_rsp_status        <= i_access_status;
                            r_rsp_read_data     <= i_access_read_data;
                        end
                    end else if (w_timeout) begin
                        r_state          <= c_state_resp;
                        r_access_valid   <= 1'b0;
                        r_access_address <= '0;
                        r_access_mask    <= '0;
                        r_rsp_valid      <= 1'b1;
                        r_rsp_status     <= c_status_timeout;
                        r_rsp_read_data  <= '0;
                    end
                end

                c_state_write: begin
                    if (w_complete || w_timeout) begin
                        r_state             <= c_state_resp;
                        r_access_valid      <= 1'b0;
                        r_access_write      <= 1'b0;
                        r_access_address    <= '0;
                        r_access_write_data <= '0;
                        r_access_mask       <= '0;
                        r_rsp_valid         <= 1'b1;
                        if (w_complete) begin
                            r_rsp_status    <= i_access_status;
                            r_rsp_read_data <= r_rmw ? r_read_data : '0;
                        end else begin
                            r_rsp_status    <= c_status_timeout;
                            r_rsp_read_data <= '0;
                        end
                    end
                end

                c_state_resp: begin
                    if (i_rsp_ready) begin
                        r_state         <= c_state_idle;
                        r_rsp_valid     <= 1'b0;
                        r_rsp_status    <= c_status_ok;
                        r_rsp_read_data <= '0;
                    end
                end

                default: begin
                    r_state <= c_state_idle;
                end
            endcase
        end
    end

    assign o_cmd_ready         = (r_state == c_state_idle);
    assign o_access_valid      = r_access_valid;
    assign o_access_write      = r_access_write;
    assign o_access_address    = r_access_address;
    assign o_access_write_data = r_access_write_data;
    assign o_access_mask       = r_access_mask;
    assign o_rsp_valid         = r_rsp_valid;
    assign o_rsp_status        = r_rsp_status;
    assign o_rsp_read_data     = r_rsp_read_data;

endmodule

`default_nettype wire

// File: tb/tb_rggen_register_access_initiator.sv
//------------------------------------------------------------------------------
// Module   : tb_rggen_register_access_initiator
// Purpose  : Self-checking bench for rggen_register_access_initiator.
//            Directed table plus random commands against a transaction-level
//            model of the expected accesses and response.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rggen_register_access_initiator;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int T  = 4;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_cmd_valid = 1'b0;
    logic          o_cmd_ready;
    logic [1:0]    i_cmd_kind = 2'b00;
    logic [AW-1:0] i_cmd_address = '0;
    logic [DW-1:0] i_cmd_write_data = '0;
    logic [DW-1:0] i_cmd_mask = '0;
    logic          o_access_valid;
    logic          o_access_write;
    logic [AW-1:0] o_access_address;
    logic [DW-1:0] o_access_write_data;
    logic [DW-1:0] o_access_mask;
    logic          i_access_ready = 1'b0;
    logic [1:0]    i_access_status = 2'b00;
    logic [DW-1:0] i_access_read_data = '0;
    logic          o_rsp_valid;
    logic          i_rsp_ready = 1'b0;
    logic [1:0]    o_rsp_status;
    logic [DW-1:0] o_rsp_read_data;

    always #5 i_clk = ~i_clk;

    rggen_register_access_initiator #(
        .ADDRESS_WIDTH  (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (T),
        .TIMEOUT_WIDTH  (8)
    ) dut (
        .i_clk               (i_clk),
        .i_rst_n             (i_rst_n),
        .i_cmd_valid         (i_cmd_valid),
        .o_cmd_ready         (o_cmd_ready),
        .i_cmd_kind          (i_cmd_kind),
        .i_cmd_address       (i_cmd_address),
        .i_cmd_write_data    (i_cmd_write_data),
        .i_cmd_mask          (i_cmd_mask),
        .o_access_valid      (o_access_valid),
        .o_access_write      (o_access_write),
        .o_access_address    (o_access_address),
        .o_access_write_data (o_access_write_data),
        .o_access_mask       (o_access_mask),
        .i_access_ready      (i_access_ready),
        .i_access_status     (i_access_status),
        .i_access_read_data  (i_access_read_data),
        .o_rsp_valid         (o_rsp_valid),
        .i_rsp_ready         (i_rsp_ready),
        .o_rsp_status        (o_rsp_status),
        .o_rsp_read_data     (o_rsp_read_data)
    );

    // One command plus the responder behaviour and, for directed rows,
    // hand-derived expectations (exp_lat / exp_vcyc0 of -1 mean "not checked").
    typedef struct {
        logic [1:0]    kind;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] mask;
        logic [DW-1:0] rd;
        int            dly_r;
        int            dly_w;
        logic [1:0]    st_r;
        logic [1:0]    st_w;
        int            hold;
        logic [1:0]    exp_st;
        logic [DW-1:0] exp_data;
        int            exp_nacc;
        int            exp_lat;
        int            exp_vcyc0;
        bit            chk_w;
        logic [DW-1:0] exp_lw;
        logic [DW-1:0] exp_lm;
    } vec_t;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] mask;
        int            vcyc;
    } acc_t;

    acc_t obs_q[$];
    acc_t exp_q[$];
    vec_t tbl[10];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [1:0] kind, input logic [AW-1:0] addr,
        input logic [DW-1:0] wdata, input logic [DW-1:0] mask, input logic [DW-1:0] rd,
        input int dly_r, input int dly_w, input logic [1:0] st_r, input logic [1:0] st_w,
        input int hold, input logic [1:0] exp_st, input logic [DW-1:0] exp_data,
        input int exp_nacc, input int exp_lat, input int exp_vcyc0,
        input bit chk_w, input logic [DW-1:0] exp_lw, input logic [DW-1:0] exp_lm);
        vec_t v;
        v.kind = kind; v.addr = addr; v.wdata = wdata; v.mask = mask; v.rd = rd;
        v.dly_r = dly_r; v.dly_w = dly_w; v.st_r = st_r; v.st_w = st_w; v.hold = hold;
        v.exp_st = exp_st; v.exp_data = exp_data; v.exp_nacc = exp_nacc;
        v.exp_lat = exp_lat; v.exp_vcyc0 = exp_vcyc0; v.chk_w = chk_w;
        v.exp_lw = exp_lw; v.exp_lm = exp_lm;
        return v;
    endfunction

    // Reference model: one bus phase. A responder that waits dly cycles
    // completes after dly+1 valid cycles unless that exceeds the timeout.
    task automatic model_phase(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                               input logic [DW-1:0] m, input int dly, output bit ok);
        acc_t e;
        e.wr = wr; e.addr = a; e.wdata = wd; e.mask = m;
        ok = (dly < T);
        e.vcyc = ok ? dly + 1 : T;
        exp_q.push_back(e);
    endtask

    task automatic model(input vec_t v, output logic [1:0] st, output logic [DW-1:0] d);
        bit ok;
        exp_q.delete();
        st = 2'b11;
        d  = '0;
        case (v.kind)
            2'b00: begin
                model_phase(1'b0, v.addr, '0, v.mask, v.dly_r, ok);
                if (ok) begin st = v.st_r; d = v.rd; end
            end
            2'b01: begin
                model_phase(1'b1, v.addr, v.wdata, v.mask, v.dly_w, ok);
                if (ok) st = v.st_w;
            end
            2'b10: begin
                model_phase(1'b0, v.addr, '0, v.mask, v.dly_r, ok);
                if (ok && v.st_r != 2'b00) begin
                    st = v.st_r; d = v.rd;
                end else if (ok) begin
                    model_phase(1'b1, v.addr, (v.rd & ~v.mask) | (v.wdata & v.mask), '1, v.dly_w, ok);
                    if (ok) begin st = v.st_w; d = v.rd; end
                end
            end
            default: ;
        endcase
    endtask

    // Issues one command and plays responder and response consumer.
    // Entered and left just after a rising edge.
    task automatic run_txn(input vec_t v, output logic [1:0] st, output logic [DW-1:0] d, output int lat);
        int cyc, wait_cnt, hold_cnt, rsp_err, acc_err, idx;
        bit in_acc, seen, done;
        acc_t a;
        obs_q.delete();
        st = 2'b00; d = '0; lat = -1;
        wait_cnt = 0; hold_cnt = 0; rsp_err = 0; acc_err = 0; idx = 0;
        in_acc = 1'b0; seen = 1'b0; done = 1'b0;
        chk("cmd_ready_idle", {63'd0, o_cmd_ready}, 64'd1);
        i_cmd_valid = 1'b1;
        i_cmd_kind = v.kind; i_cmd_address = v.addr;
        i_cmd_write_data = v.wdata; i_cmd_mask = v.mask;
        @(posedge i_clk); #1;
        i_cmd_valid = 1'b0;
        i_cmd_kind = 2'($urandom); i_cmd_address = AW'($urandom);
        cyc = 1;
        while (!done && cyc < 60) begin
            i_access_ready = 1'b0;
            i_access_status = 2'($urandom);
            i_access_read_data = $urandom;
            i_rsp_ready = 1'b0;
            if (o_access_valid) begin
                if (!in_acc) begin
                    a.wr = o_access_write; a.addr = o_access_address;
                    a.wdata = o_access_write_data; a.mask = o_access_mask; a.vcyc = 0;
                    obs_q.push_back(a);
                    idx = obs_q.size() - 1;
                    in_acc = 1'b1; wait_cnt = 0;
                end else if (obs_q[idx].wr !== o_access_write || obs_q[idx].addr !== o_access_address ||
                             obs_q[idx].wdata !== o_access_write_data || obs_q[idx].mask !== o_access_mask) begin
                    acc_err++;
                end
                obs_q[idx].vcyc = obs_q[idx].vcyc + 1;
                if (wait_cnt == (o_access_write ? v.dly_w : v.dly_r)) begin
                    i_access_ready = 1'b1;
                    i_access_status = o_access_write ? v.st_w : v.st_r;
                    i_access_read_data = v.rd;
                    in_acc = 1'b0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                in_acc = 1'b0;
            end
            if (o_rsp_valid) begin
                if (!seen) begin
                    seen = 1'b1; st = o_rsp_status; d = o_rsp_read_data; lat = cyc; hold_cnt = 0;
                end else if (o_rsp_status !== st || o_rsp_read_data !== d) begin
                    rsp_err++;
                end
                if (hold_cnt == v.hold) begin
                    i_rsp_ready = 1'b1;
                    done = 1'b1;
                end else begin
                    hold_cnt++;
                end
            end
            @(posedge i_clk); #1;
            cyc++;
        end
        i_access_ready = 1'b0;
        i_rsp_ready = 1'b0;
        chk("txn_completed", {63'd0, done}, 64'd1);
        chk("access_stable", 64'(acc_err), 64'd0);
        chk("rsp_stable", 64'(rsp_err), 64'd0);
    endtask

    task automatic check_txn(input vec_t v, input bit directed);
        logic [1:0] st, mst;
        logic [DW-1:0] d, md;
        int lat, n;
        model(v, mst, md);
        run_txn(v, st, d, lat);
        chk("model_status", 64'(st), 64'(mst));
        chk("model_data", 64'(d), 64'(md));
        chk("model_naccess", 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk("acc_write", {63'd0, obs_q[i].wr}, {63'd0, exp_q[i].wr});
            chk("acc_addr", 64'(obs_q[i].addr), 64'(exp_q[i].addr));
            chk("acc_mask", 64'(obs_q[i].mask), 64'(exp_q[i].mask));
            chk("acc_valid_cycles", 64'(obs_q[i].vcyc), 64'(exp_q[i].vcyc));
            if (exp_q[i].wr) chk("acc_wdata", 64'(obs_q[i].wdata), 64'(exp_q[i].wdata));
        end
        if (directed) begin
            chk("tbl_status", 64'(st), 64'(v.exp_st));
            chk("tbl_data", 64'(d), 64'(v.exp_data));
            chk("tbl_naccess", 64'(obs_q.size()), 64'(v.exp_nacc));
            if (v.exp_lat >= 0) chk("tbl_latency", 64'(lat), 64'(v.exp_lat));
            if (obs_q.size() > 0) begin
                if (v.exp_vcyc0 >= 0) chk("tbl_valid_cycles", 64'(obs_q[0].vcyc), 64'(v.exp_vcyc0));
                chk("tbl_last_mask", 64'(obs_q[obs_q.size()-1].mask), 64'(v.exp_lm));
                if (v.chk_w) chk("tbl_last_wdata", 64'(obs_q[obs_q.size()-1].wdata), 64'(v.exp_lw));
            end
        end
    endtask

    initial begin
        vec_t v;
        //            kind   addr      wdata         mask          rd            dr dw sr     sw     hold st     data          n  lat vc0 w  lw            lm
        tbl[0] = mk(2'b00, 16'h0010, 32'h0,        32'hFFFFFFFF, 32'hA5A50001, 2, 0, 2'b00, 2'b00, 0, 2'b00, 32'hA5A50001, 1, -1, 3, 0, 32'h0,        32'hFFFFFFFF);
        tbl[1] = mk(2'b01, 16'h0020, 32'h12345678, 32'h0000FFFF, 32'h0,        0, 0, 2'b00, 2'b00, 0, 2'b00, 32'h0,        1,  2, 1, 1, 32'h12345678, 32'h0000FFFF);
        tbl[2] = mk(2'b10, 16'h0030, 32'h00000050, 32'h000000F0, 32'hFFFFFF0F, 0, 0, 2'b00, 2'b00, 0, 2'b00, 32'hFFFFFF0F, 2,  3, 1, 1, 32'hFFFFFF5F, 32'hFFFFFFFF);
        tbl[3] = mk(2'b10, 16'h0034, 32'h00000050, 32'h000000F0, 32'hDEAD0000, 0, 0, 2'b10, 2'b00, 0, 2'b10, 32'hDEAD0000, 1,  2, 1, 0, 32'h0,        32'h000000F0);
        tbl[4] = mk(2'b00, 16'h0040, 32'h0,        32'hFFFFFFFF, 32'h0,       99, 0, 2'b00, 2'b00, 0, 2'b11, 32'h0,        1,  5, 4, 0, 32'h0,        32'hFFFFFFFF);
        tbl[5] = mk(2'b00, 16'h0044, 32'h0,        32'hFFFFFFFF, 32'h11112222, 3, 0, 2'b00, 2'b00, 0, 2'b00, 32'h11112222, 1,  5, 4, 0, 32'h0,        32'hFFFFFFFF);
        tbl[6] = mk(2'b11, 16'h0048, 32'h0,        32'h0,        32'h0,        0, 0, 2'b00, 2'b00, 0, 2'b11, 32'h0,        0,  1, -1, 0, 32'h0,       32'h0);
        tbl[7] = mk(2'b01, 16'h004C, 32'hCAFE0000, 32'hFFFF0000, 32'h0,        0, 1, 2'b00, 2'b10, 5, 2'b10, 32'h0,        1,  3, 2, 1, 32'hCAFE0000, 32'hFFFF0000);
        tbl[8] = mk(2'b01, 16'h0050, 32'h0000AAAA, 32'h0,        32'h0,        0, 0, 2'b00, 2'b00, 0, 2'b00, 32'h0,        1,  2, 1, 1, 32'h0000AAAA, 32'h0);
        tbl[9] = mk(2'b10, 16'h0054, 32'h00000005, 32'h0000000F, 32'hFFFFFFFF, 0,99, 2'b00, 2'b00, 0, 2'b11, 32'h0,        2,  6, 1, 1, 32'hFFFFFFF5, 32'hFFFFFFFF);

        // Reset state, checked while reset is still asserted
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset_cmd_ready", {63'd0, o_cmd_ready}, 64'd1);
        chk("reset_access_zero", {o_access_valid, o_access_write, o_access_address, o_access_write_data[13:0]}, 64'd0);
        chk("reset_rsp_zero", {29'd0, o_rsp_valid, o_rsp_status, o_rsp_read_data}, 64'd0);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        for (int i = 0; i < 10; i++) check_txn(tbl[i], 1'b1);

        for (int i = 0; i < 40; i++) begin
            v = mk(2'($urandom), AW'($urandom), $urandom, $urandom, $urandom,
                   $urandom_range(0, 5), $urandom_range(0, 5),
                   ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom),
                   ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom),
                   $urandom_range(0, 2), 2'b00, '0, 0, -1, -1, 1'b0, '0, '0);
            check_txn(v, 1'b0);
        end

        // Reset in the middle of a write phase with an unresponsive slave
        i_cmd_valid = 1'b1; i_cmd_kind = 2'b01; i_cmd_address = 16'h0060;
        i_cmd_write_data = 32'h55AA55AA; i_cmd_mask = 32'hFFFFFFFF;
        @(posedge i_clk); #1;
        i_cmd_valid = 1'b0;
        @(posedge i_clk); #1;
        chk("pre_reset_write_valid", {62'd0, o_access_valid, o_access_write}, 64'd3);
        #2 i_rst_n = 1'b0;
        #1;
        chk("midrst_cmd_ready", {63'd0, o_cmd_ready}, 64'd1);
        chk("midrst_access_zero", {o_access_valid, o_access_write, o_access_address, o_access_write_data[13:0]}, 64'd0);
        chk("midrst_mask_zero", 64'(o_access_mask), 64'd0);
        chk("midrst_rsp_zero", {29'd0, o_rsp_valid, o_rsp_status, o_rsp_read_data}, 64'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge i_clk); #1;
            chk("post_reset_quiet", {61'd0, o_rsp_valid, o_access_valid, o_cmd_ready}, 64'd1);
        end

        // Normal service after the abort
        check_txn(tbl[1], 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/rggen_register_access_initiator.md
Name: rggen_register_access_initiator

Overview:
- Software-side initiator for the register-access interface that bit fields respond to.
- Accepts read, write and read-modify-write (RMW) commands on a valid/ready command port.
- Drives the register access bus (valid, write, address, data, mask), waits for the responder's ready, and returns status and read data on a valid/ready response port.
- Sits between a bus bridge or embedded sequencer and the register block; it is the requester for the bit fields' software update path.

Parameters:
- ADDRESS_WIDTH, 16, width of the access address.
- DATA_WIDTH, 32, width of data and mask.
- TIMEOUT_CYCLES, 16, cycles to wait for i_access_ready before aborting; 0 disables the timeout.
- TIMEOUT_WIDTH, 8, width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2**TIMEOUT_WIDTH.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_cmd_valid  input  1  command valid.
- o_cmd_ready  output  1  command accepted; high only in IDLE.
- i_cmd_kind  input  2  00 read, 01 write, 10 RMW, 11 reserved.
- i_cmd_address  input  ADDRESS_WIDTH  target address.
- i_cmd_write_data  input  DATA_WIDTH  write data.
- i_cmd_mask  input  DATA_WIDTH  bit enables.
- o_access_valid  output  1  access request.
- o_access_write  output  1  1 = write, 0 = read.
- o_access_address  output  ADDRESS_WIDTH  access address.
- o_access_write_data  output  DATA_WIDTH  access write data.
- o_access_mask  output  DATA_WIDTH  access mask.
- i_access_ready  input  1  responder completes the access this cycle.
- i_access_status  input  2  responder status, sampled with ready.
- i_access_read_data  input  DATA_WIDTH  read data, sampled with ready.
- o_rsp_valid  output  1  response valid.
- i_rsp_ready  input  1  response consumed.
- o_rsp_status  output  2  00 OK, 01 reserved, 10 slave error, 11 timeout/illegal.
- o_rsp_read_data  output  DATA_WIDTH  read data (read and RMW); 0 for write.

Behaviour:
- Reset: state IDLE; o_cmd_ready = 1; every other output 0; timeout counter 0. Reset asserted mid-operation aborts immediately with no response.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: command accepted on i_cmd_valid && o_cmd_ready. All command fields are captured into registers.
  - Read → READ.
  - Write → WRITE.
  - RMW → READ.
  - Kind 11 → RESP with status 11 and data 0; no access is issued.
- Access request timing: o_access_valid rises the cycle after acceptance and all o_access_* outputs are registered. Minimum command-to-response latency is 2 cycles, with i_access_ready high on the first valid cycle.
- Handshake: o_access_* stays stable while valid && !ready. An access completes on the cycle valid && i_access_ready; o_access_valid deasserts the next cycle unless the next phase follows.
- READ phase: o_access_write = 0; o_access_mask = captured mask.
  - On completion, capture the read data.
  - Plain read → RESP with the responder's status.
  - RMW with status OK → WRITE. The write data is (rdata & ~mask) | (wdata & mask), the write mask is all ones, and valid stays high across the phase change.
  - RMW with non-OK status → RESP with that status; the write phase is skipped.
- WRITE phase: o_access_write = 1, with the captured data and mask. On completion → RESP with the responder's status.
  - Response data is 0 for a plain write.
  - For RMW, response data is the value read in the READ phase.
- Timeout:
  - The counter clears on every phase entry and increments each cycle with valid && !ready.
  - When it reaches TIMEOUT_CYCLES, the access is aborted: valid drops the next cycle and the FSM goes to RESP with status 11.
  - A ready arriving in the same cycle as the terminal count wins: normal completion.
- RESP: o_rsp_valid is held with stable status and data until i_rsp_ready; then → IDLE with o_cmd_ready = 1. The earliest next acceptance is the cycle after the response handshake; there is no pipelining.
- Mask of 0: the access is still issued; the responder defines the effect.

Decomposition:
- Shared package/header rggen_register_access_defines: command-kind codes, status codes, FSM state encodings.
- Optional sub-module rggen_access_timeout_counter: counter with clear/enable and a terminal-count flag. Everything else stays in one module.

Test Plan:
- Read addr 0x0010, mask 0xFFFFFFFF; responder ready after 2 cycles, data 0xA5A5_0001, status 00 → one read access held stable for 3 cycles; response status 00, data 0xA5A5_0001.
- Write addr 0x0020, data 0x1234_5678, mask 0x0000_FFFF; ready immediately → o_access_write = 1 for exactly 1 cycle, response status 00, data 0; command-to-response latency 2 cycles.
- RMW: mask 0x0000_00F0, wdata 0x0000_0050, read returns 0xFFFF_FF0F → write data 0xFFFF_FF5F, write mask 0xFFFFFFFF; response data 0xFFFF_FF0F, status 00.
- RMW where the read returns status 10 → no write access; response status 10.
- Responder never ready, TIMEOUT_CYCLES = 4 → valid high 4 cycles then low; response status 11. Repeat with ready on the 4th cycle → status 00.
- Kind 11 → no access, response status 11. Also: reset asserted during the WRITE phase → all outputs 0 and o_cmd_ready = 1 immediately; i_rsp_ready held low for 5 cycles → response stable throughout.
